// File: rtl/trig_rec_pkg.sv
// Shared constants and record layout for the trigger event recorder.
package trig_rec_pkg;

  localparam int unsigned TS_W  = 56;
  localparam int unsigned ID_W  = 8;
  localparam int unsigned REC_W = ID_W + TS_W;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [TS_W-1:0] ts;
  } rec_t;

endpackage

// File: rtl/trig_rec_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head word.
module trig_rec_fifo #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned W          = 64
) (
  input  logic                  clk_adc,
  input  logic                  nrst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [W-1:0]          din,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [W-1:0]          rd_data,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [W-1:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [DEPTH_LOG2-1:0]   head_ptr;
  logic                    pop;
  logic                    wr_en;
  logic [DEPTH_LOG2:0]     cnt_after_pop;
  logic [DEPTH_LOG2:0]     cnt_next;

  // count never exceeds DEPTH, so its MSB alone marks the full state
  always_comb begin
    pop           = rd_valid & rd_ready;
    full          = count[DEPTH_LOG2];
    wr_en         = push & (~full | pop);
    cnt_after_pop = count - (DEPTH_LOG2 + 1)'(pop);
    cnt_next      = cnt_after_pop + (DEPTH_LOG2 + 1)'(wr_en);
    head_ptr      = rd_ptr + DEPTH_LOG2'(pop);
  end

  always_ff @(posedge clk_adc) begin
    if (nrst && !flush && wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  // Head register: bypass the incoming word when it becomes the only entry,
  // otherwise preload the entry that follows the current head.
  always_ff @(posedge clk_adc) begin
    if (!nrst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      rd_ptr   <= head_ptr;
      count    <= cnt_next;
      rd_valid <= (cnt_next != '0);
      if (wr_en && cnt_after_pop == '0) begin
        rd_data <= din;
      end else if (cnt_after_pop != '0) begin
        rd_data <= mem[head_ptr];
      end
    end
  end

endmodule

// File: rtl/trig_event_recorder.sv
// Records {trig_id, timestamp} for every rising trigger edge into an FWFT FIFO
// drained by the slow-control readout.
module trig_event_recorder #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned TS_W       = 56,
  parameter int unsigned ID_W       = 8,
  parameter int unsigned NOUT       = 16
) (
  input  logic                  clk_adc,
  input  logic                  nrst,
  input  logic [NOUT-1:0]       trig_out,
  input  logic [NOUT-1:0]       out_mask,
  input  logic [ID_W-1:0]       trig_id,
  input  logic [TS_W-1:0]       clock_counter,
  input  logic                  rec_enable,
  input  logic                  clear,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [ID_W+TS_W-1:0]  rd_data,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic [15:0]           dropped,
  output logic                  overflow
);

  import trig_rec_pkg::*;

  logic [NOUT-1:0]       prev;
  logic [NOUT-1:0]       edges;
  logic                  evt;
  logic                  cap_valid;
  logic [ID_W+TS_W-1:0]  cap_data;
  logic                  full;
  logic                  drop;
  logic                  push;

  always_comb begin
    edges = trig_out & ~prev & out_mask;
    evt   = rec_enable & (|edges);
    push  = cap_valid & ~clear;
    drop  = cap_valid & full & ~(rd_valid & rd_ready);
  end

  // prev keeps tracking during clear so an edge coincident with clear is consumed
  always_ff @(posedge clk_adc) begin
    if (!nrst) begin
      prev      <= '0;
      cap_valid <= 1'b0;
      cap_data  <= '0;
      dropped   <= '0;
      overflow  <= 1'b0;
    end else begin
      prev <= trig_out;
      if (clear) begin
        cap_valid <= 1'b0;
        dropped   <= '0;
        overflow  <= 1'b0;
      end else begin
        cap_valid <= evt;
        if (evt) begin
          cap_data <= {trig_id, clock_counter};
        end
        if (drop) begin
          overflow <= 1'b1;
          if (dropped != DROP_MAX) begin
            dropped <= dropped + 16'd1;
          end
        end
      end
    end
  end

  trig_rec_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .W          (ID_W + TS_W)
  ) u_fifo (
    .clk_adc  (clk_adc),
    .nrst     (nrst),
    .flush    (clear),
    .push     (push),
    .din      (cap_data),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .full     (full),
    .count    (fill_level)
  );

endmodule
